window_7x7: RTL and testbench
=============================

# window_7x7

Downstream consumer of the 7-line buffer: takes the seven vertically aligned row taps it emits per pixel and assembles a full 7x7 pixel window via per-row horizontal shift registers. It tracks column and output-row position against the runtime image size, and flags only windows lying entirely inside the image. The window bus feeds the 7x7 filter/compute stages.

## Interface
- Parameters: none; all constants come from `win7_pkg`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `IMG_SIZE_I`  in  9  square image side in pixels, 1..511; latched at frame start.
- `row0_i`..`row6_i`  in  8 each  aligned taps; `row0_i` is the oldest (top) line, `row6_i` the current (bottom) line.
- `row_valid_i`  in  1  all seven taps valid this cycle; one beat per image column.
- `win_o`  out  392  window; pixel (r,c) at bits `[8*(7*r+c) +: 8]`; r=0 top, c=0 leftmost/oldest; centre is index 24.
- `win_valid_o`  out  1  `win_o` holds a fully interior window.
- `frame_done_o`  out  1  one-cycle pulse after the last window of a frame.
- `win_row_o` / `win_col_o`  out  9 each  window-centre coordinates; present only with `WIN7_COORD_EN`.

## Operation
- The upstream buffer asserts `row_valid_i` only once all seven lines are filled. Each frame therefore presents (S-6)*S beats, where S is the latched size.
- On each beat, every row shifts left by one and the new tap enters column 6.
- With no beat, all state holds. No backpressure; every beat is accepted.
- Column counter `col` runs 0..S-1 and wraps to 0. On wrap, output-row counter `orow` increments.
- Frame end: the beat with `orow`=S-7 and `col`=S-1. That beat still produces its window. Then `frame_done_o` pulses and both counters clear.
- Size latch: `IMG_SIZE_I` is captured on the first beat while `col`=`orow`=0. Changes mid-frame are ignored until the next frame.
- Window validity: window is valid iff the accepted beat has `col` >= 6.
- S < 7: `win_valid_o` never asserts. `col` still wraps at S. `orow` wraps at 0 and `frame_done_o` pulses on every line wrap.
- Shift contents are never cleared between lines. Windows straddling a line boundary are invalidated by the `col` rule alone.

## Timing
- Latency: one cycle from an accepted beat to `win_o`/`win_valid_o`, both registered.
- `win_valid_o` is a single-cycle pulse per qualifying beat. It is back-to-back for consecutive beats.
- `frame_done_o` asserts in the same cycle as the final `win_valid_o`.
- Reset value of every output and all internal state is 0, including `win_o`, the coordinates and the latched size.
- Reset mid-frame: state clears immediately. The next beat is treated as column 0 of a new frame, and the size is re-latched.
- A beat arriving on the cycle after frame end is column 0 of the next frame; there is no dead cycle.

## Configuration
- `WIN7_COORD_EN` defined:
  - `win_row_o` = `orow`+3 of the beat that produced the window.
  - `win_col_o` = `col`-3 of that beat.
  - Both registered alongside `win_o`, reset 0.
- Undefined: the ports do not exist and no coordinate registers are built. Counter logic is unchanged.

## Structure
- `win7_pkg` holds:
  - `K`=7, `PIX_W`=8, `SIZE_W`=9;
  - `typedef pixel_t` (8-bit);
  - `typedef window_t` (49 x `pixel_t`, packed).
- Sub-module `win7_row_shift`: 7-deep, 8-bit shift register with enable and async clear. It is instantiated seven times, once per row. Counters, size latch and output registers stay in the top level.

## Test plan
Stimulus below drives tap k = 8'h10*k + `col`.
- S=8, 16 continuous beats:
  - exactly 4 `win_valid_o` pulses, at `col` 6,7 of `orow` 0,1;
  - first window pixel (0,0)=8'h00 and (6,6)=8'h66;
  - `frame_done_o` pulses with the 4th window.
- Same S=8 run with `row_valid_i` toggled every other cycle: identical 4 windows, each 1 cycle after its beat; all state holds across gaps.
- S=5, 20 beats: `win_valid_o` never asserts; `frame_done_o` pulses every 5 beats.
- S=8: change `IMG_SIZE_I` to 10 at beat 5.
  - Current frame still ends after 16 beats.
  - Next frame uses S=10: 40 beats, 16 windows.
- Assert `rst_n`=0 at beat 10 of an S=8 frame:
  - all outputs read 0;
  - after release, the first window appears at the 7th new beat.
- With `WIN7_COORD_EN`, S=8: coordinates of the 4 windows are (3,3), (3,4), (4,3), (4,4).

Source files
------------

// File: rtl/win7_pkg.sv
// Shared constants and pixel/window types for the 7x7 window assembler.
package win7_pkg;
  localparam int K      = 7;
  localparam int PIX_W  = 8;
  localparam int SIZE_W = 9;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [K*K-1:0] window_t;
endpackage

// File: rtl/win7_row_shift.sv
// One window row: 7-deep pixel shift register, new pixel enters the top (column 6).
module win7_row_shift
  import win7_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PIX_W-1:0]     din,
  output logic [K*PIX_W-1:0]   taps
);

  pixel_t [K-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr <= {din, sr[K-1:1]};
    end
  end

  assign taps = sr;

endmodule

// File: rtl/window_7x7.sv
// Assembles a 7x7 window from seven aligned row taps; flags windows fully inside the image.
// Optional WIN7_COORD_EN adds registered window-centre coordinates.
module window_7x7
  import win7_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIZE_W-1:0]    IMG_SIZE_I,
  input  logic [PIX_W-1:0]     row0_i,
  input  logic [PIX_W-1:0]     row1_i,
  input  logic [PIX_W-1:0]     row2_i,
  input  logic [PIX_W-1:0]     row3_i,
  input  logic [PIX_W-1:0]     row4_i,
  input  logic [PIX_W-1:0]     row5_i,
  input  logic [PIX_W-1:0]     row6_i,
  input  logic                 row_valid_i,
  output logic [K*K*PIX_W-1:0] win_o,
  output logic                 win_valid_o,
  output logic                 frame_done_o
`ifdef WIN7_COORD_EN
  ,
  output logic [SIZE_W-1:0]    win_row_o,
  output logic [SIZE_W-1:0]    win_col_o
`endif
);

  logic [SIZE_W-1:0] col;
  logic [SIZE_W-1:0] orow;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] eff_size;
  logic              frame_start;
  logic              last_col;
  logic              small_img;
  logic              frame_end;
  pixel_t [K-1:0]    taps_in;
  window_t           win;

  assign taps_in = {row6_i, row5_i, row4_i, row3_i, row2_i, row1_i, row0_i};

  for (genvar r = 0; r < K; r++) begin : g_row
    win7_row_shift u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (row_valid_i),
      .din   (taps_in[r]),
      .taps  (win[r*K +: K])
    );
  end

  assign win_o = win;

  // The first beat of a frame already uses the incoming size, before it is latched.
  assign frame_start = (col == '0) && (orow == '0);
  assign eff_size    = frame_start ? IMG_SIZE_I : size_q;
  assign last_col    = (col == eff_size - SIZE_W'(1));
  assign small_img   = (eff_size < SIZE_W'(K));
  assign frame_end   = last_col && (small_img || (orow == eff_size - SIZE_W'(K)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      orow         <= '0;
      size_q       <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      if (row_valid_i) begin
        if (frame_start) begin
          size_q <= IMG_SIZE_I;
        end
        win_valid_o  <= (col >= SIZE_W'(K-1));
        frame_done_o <= frame_end;
        if (frame_end) begin
          col  <= '0;
          orow <= '0;
        end else if (last_col) begin
          col  <= '0;
          orow <= orow + SIZE_W'(1);
        end else begin
          col  <= col + SIZE_W'(1);
        end
      end
    end
  end

`ifdef WIN7_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row_o <= '0;
      win_col_o <= '0;
    end else if (row_valid_i) begin
      win_row_o <= orow + SIZE_W'(3);
      win_col_o <= col - SIZE_W'(3);
    end
  end
`endif

endmodule

// File: tb/tb_window_7x7.sv
// Directed, table-driven bench for window_7x7; tap k carries 8'h10*k + column.
module tb_window_7x7;
  import win7_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [8:0]        img_size;
  logic [7:0]        r0, r1, r2, r3, r4, r5, r6;
  logic              row_valid;
  logic [391:0]      win;
  logic              win_valid;
  logic              frame_done;
`ifdef WIN7_COORD_EN
  logic [8:0]        win_row;
  logic [8:0]        win_col;
`endif

  int checks   = 0;
  int failures = 0;
  int nvalid;

  always #5 clk = ~clk;

  window_7x7 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IMG_SIZE_I   (img_size),
    .row0_i       (r0),
    .row1_i       (r1),
    .row2_i       (r2),
    .row3_i       (r3),
    .row4_i       (r4),
    .row5_i       (r5),
    .row6_i       (r6),
    .row_valid_i  (row_valid),
    .win_o        (win),
    .win_valid_o  (win_valid),
    .frame_done_o (frame_done)
`ifdef WIN7_COORD_EN
    ,
    .win_row_o    (win_row),
    .win_col_o    (win_col)
`endif
  );

  typedef struct {
    logic [3:0] col;
    logic       v;
    logic       d;
    logic [7:0] p00;
    logic [7:0] p66;
    logic [8:0] wr;
    logic [8:0] wc;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return win[8*(7*r+c) +: 8];
  endfunction

  task automatic beat(input logic [3:0] c);
    r0 = 8'h00 + {4'h0, c};
    r1 = 8'h10 + {4'h0, c};
    r2 = 8'h20 + {4'h0, c};
    r3 = 8'h30 + {4'h0, c};
    r4 = 8'h40 + {4'h0, c};
    r5 = 8'h50 + {4'h0, c};
    r6 = 8'h60 + {4'h0, c};
    row_valid = 1'b1;
    @(posedge clk);
    #1;
    row_valid = 1'b0;
  endtask

  task automatic idle();
    row_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input int i);
    check({tag, "_valid"}, win_valid, tbl[i].v);
    check({tag, "_done"}, frame_done, tbl[i].d);
    if (tbl[i].v) begin
      check({tag, "_p00"}, pix(0, 0), tbl[i].p00);
      check({tag, "_p66"}, pix(6, 6), tbl[i].p66);
`ifdef WIN7_COORD_EN
      check({tag, "_wrow"}, win_row, tbl[i].wr);
      check({tag, "_wcol"}, win_col, tbl[i].wc);
`endif
    end
  endtask

  initial begin
    // S=8 frame: windows at col 6,7 of orow 0,1; done with the 4th.
    tbl[0]  = '{4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[1]  = '{4'd1, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[2]  = '{4'd2, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[3]  = '{4'd3, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[4]  = '{4'd4, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[5]  = '{4'd5, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[6]  = '{4'd6, 1'b1, 1'b0, 8'h00, 8'h66, 9'd3, 9'd3};
    tbl[7]  = '{4'd7, 1'b1, 1'b0, 8'h01, 8'h67, 9'd3, 9'd4};
    tbl[8]  = '{4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[9]  = '{4'd1, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[10] = '{4'd2, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[11] = '{4'd3, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[12] = '{4'd4, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[13] = '{4'd5, 1'b0, 1'b0, 8'h00, 8'h00, 9'd0, 9'd0};
    tbl[14] = '{4'd6, 1'b1, 1'b0, 8'h00, 8'h66, 9'd4, 9'd3};
    tbl[15] = '{4'd7, 1'b1, 1'b1, 8'h01, 8'h67, 9'd4, 9'd4};

    rst_n = 1'b0;
    img_size = 9'd8;
    row_valid = 1'b0;
    {r0, r1, r2, r3, r4, r5, r6} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win", {63'd0, |win}, 64'd0);
    check("rst_valid", win_valid, 0);
    check("rst_done", frame_done, 0);
`ifdef WIN7_COORD_EN
    check("rst_wrow", win_row, 0);
    check("rst_wcol", win_col, 0);
`endif
    rst_n = 1'b1;
    idle();

    // Continuous S=8 frame.
    for (int i = 0; i < 16; i++) begin
      beat(tbl[i].col);
      check_vec("cont", i);
    end

    // Same frame, beats separated by idle cycles; state must hold across gaps.
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      beat(tbl[i].col);
      if (win_valid) nvalid++;
      check_vec("gap", i);
      idle();
      check("gap_idle_valid", win_valid, 0);
      check("gap_idle_done", frame_done, 0);
      check("gap_hold_p66", pix(6, 6), 8'h60 + {4'h0, tbl[i].col});
    end
    check("gap_nvalid", nvalid, 4);

    // S=5: no windows, done every line.
    img_size = 9'd5;
    for (int i = 0; i < 20; i++) begin
      beat(4'(i % 5));
      check("s5_valid", win_valid, 0);
      check("s5_done", frame_done, (i % 5) == 4);
    end

    // S=8 frame with size changed to 10 mid-frame, then an S=10 frame.
    img_size = 9'd8;
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) img_size = 9'd10;
      beat(4'(i % 8));
      if (win_valid) nvalid++;
      check("chg8_done", frame_done, i == 15);
    end
    check("chg8_nvalid", nvalid, 4);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      beat(4'(i % 10));
      if (win_valid) nvalid++;
      check("s10_done", frame_done, i == 39);
    end
    check("s10_nvalid", nvalid, 16);

    // Reset in the middle of an S=8 frame.
    img_size = 9'd8;
    for (int i = 0; i < 10; i++) beat(4'(i % 8));
    rst_n = 1'b0;
    #1;
    check("mrst_win", {63'd0, |win}, 64'd0);
    check("mrst_valid", win_valid, 0);
    check("mrst_done", frame_done, 0);
`ifdef WIN7_COORD_EN
    check("mrst_wrow", win_row, 0);
    check("mrst_wcol", win_col, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 7; i++) begin
      beat(4'(i));
      check("mrst_first_valid", win_valid, i == 6);
    end
    check("mrst_p00", pix(0, 0), 8'h00);
    check("mrst_p66", pix(6, 6), 8'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
